// File: rtl/bus_ctrl_pkg.sv
// Shared definitions for the tri-state bus sequencing master.
// State encodings are plain logic constants so older netlists and
// waveform scripts that decode the raw state value keep working.
package bus_ctrl_pkg;

  // Width of the read wait down-counter; RD_WAIT must fit in it (0..15).
  localparam int WAIT_W = 4;

  typedef logic [2:0] state_t;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_WR_SETUP  = 3'd1;
  localparam logic [2:0] ST_WR_STROBE = 3'd2;
  localparam logic [2:0] ST_RD        = 3'd3;
  localparam logic [2:0] ST_TURN      = 3'd4;

endpackage

// File: rtl/bus_ctrl.sv
// Sequencing master for the shared tri-state data bus, upstream of the
// data driver. Write cycles drive drv_en/drv_data into the driver; read
// cycles release the bus and sample bus_data_in after RD_WAIT extra cycles.
// Every transaction ends with a one-cycle TURN state in which nobody
// drives, so driver and memory are never on the bus together.
//
// Optional build macro: BUS_CTRL_XCHECK_EN adds rsp_err, flagging reads
// whose captured data contains X or Z bits (floating or contended bus).
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | req_ready high, waiting for a request
// WR_SETUP  | driver enabled with write data, address settling
// WR_STROBE | driver enabled, bus_wr strobe high
// RD        | bus released, bus_rd high, wait counter running
// TURN      | bus idle turnaround, rsp_valid pulse
module bus_ctrl
  import bus_ctrl_pkg::*;
#(
  parameter int DWIDTH  = 8,
  parameter int AWIDTH  = 5,
  parameter int RD_WAIT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [AWIDTH-1:0] req_addr,
  input  logic [DWIDTH-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DWIDTH-1:0] rsp_rdata,
`ifdef BUS_CTRL_XCHECK_EN
  output logic              rsp_err,
`endif
  output logic [AWIDTH-1:0] bus_addr,
  output logic              bus_rd,
  output logic              bus_wr,
  output logic              drv_en,
  output logic [DWIDTH-1:0] drv_data,
  input  logic [DWIDTH-1:0] bus_data_in
);

  localparam logic [WAIT_W-1:0] RD_WAIT_INIT = WAIT_W'(RD_WAIT);

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              rd_last;

  // Last RD cycle: the wait counter has reached terminal count.
  always_comb begin
    rd_last = (state == ST_RD) && (wait_cnt == '0);
  end

  // Transaction FSM; every output is registered and set for the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      wait_cnt  <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      bus_addr  <= '0;
      bus_rd    <= 1'b0;
      bus_wr    <= 1'b0;
      drv_en    <= 1'b0;
      drv_data  <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            bus_addr  <= req_addr;
            if (req_write) begin
              drv_data <= req_wdata;
              drv_en   <= 1'b1;
              state    <= ST_WR_SETUP;
            end else begin
              bus_rd   <= 1'b1;
              wait_cnt <= RD_WAIT_INIT;
              state    <= ST_RD;
            end
          end
        end
        ST_WR_SETUP: begin
          bus_wr <= 1'b1;
          state  <= ST_WR_STROBE;
        end
        ST_WR_STROBE: begin
          bus_wr    <= 1'b0;
          drv_en    <= 1'b0;
          rsp_valid <= 1'b1;
          state     <= ST_TURN;
        end
        ST_RD: begin
          if (rd_last) begin
            rsp_rdata <= bus_data_in;
            bus_rd    <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= ST_TURN;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        ST_TURN: begin
          req_ready <= 1'b1;
          state     <= ST_IDLE;
        end
        default: begin
          // Unreachable encodings recover to a quiet bus.
          req_ready <= 1'b1;
          bus_rd    <= 1'b0;
          bus_wr    <= 1'b0;
          drv_en    <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef BUS_CTRL_XCHECK_EN
  // Flag a read whose captured data has any X/Z bit; pulses with rsp_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_err <= 1'b0;
    end else if (rd_last) begin
      rsp_err <= ((^bus_data_in) === 1'bx);
    end else begin
      rsp_err <= 1'b0;
    end
  end
`endif

endmodule
